// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the I/D-cache to main-memory arbiter.
// Block geometry is derived here so the FSM and the interface agree on widths.
package cache_mem_arbiter_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W           = $clog2(2 * WORDS_PER_BLOCK);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [IDX_W:0]    cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IC   = 2'd1,
    OWN_DC   = 2'd2
  } owner_e;

  localparam cnt_t ISSUE_END = cnt_t'(WORDS_PER_BLOCK);
  localparam idx_t LAST_IDX  = idx_t'(WORDS_PER_BLOCK - 1);

  function automatic addr_t block_base(input addr_t addr);
    return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  // OR-ing the word offset into a cleared base keeps every address inside the block.
  function automatic addr_t word_addr(input addr_t base, input idx_t idx);
    return base | addr_t'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the two cache miss ports, the memory port and the busy flag.
// slave is the arbiter's view; master is the caches-plus-memory side.
interface cache_mem_arbiter_if;
  import cache_mem_arbiter_pkg::*;

  logic  ic_req;
  addr_t ic_addr;
  logic  ic_fill_valid;
  idx_t  ic_fill_idx;
  data_t ic_fill_data;
  logic  ic_done;

  logic  dc_req;
  logic  dc_we;
  addr_t dc_addr;
  data_t dc_wdata;
  logic  dc_fill_valid;
  idx_t  dc_fill_idx;
  data_t dc_fill_data;
  logic  dc_done;

  logic  mem_en;
  logic  mem_wr;
  addr_t mem_addr;
  data_t mem_wdata;
  data_t mem_rdata;
  logic  mem_rvalid;

  logic  busy;

  modport slave (
    input  ic_req, ic_addr,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    input  mem_rdata, mem_rvalid,
    output ic_fill_valid, ic_fill_idx, ic_fill_data, ic_done,
    output dc_fill_valid, dc_fill_idx, dc_fill_data, dc_done,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output ic_req, ic_addr,
    output dc_req, dc_we, dc_addr, dc_wdata,
    output mem_rdata, mem_rvalid,
    input  ic_fill_valid, ic_fill_idx, ic_fill_data, ic_done,
    input  dc_fill_valid, dc_fill_idx, dc_fill_data, dc_done,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates one main memory between I-cache and D-cache misses: pipelined
// block fills with overlapped issue/return, or a single-cycle write-through.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  cache_mem_arbiter_if.slave  bus
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  addr_t  base_q,  base_d;
  addr_t  waddr_q, waddr_d;
  data_t  wdata_q, wdata_d;
  cnt_t   issue_cnt_q, issue_cnt_d;
  idx_t   recv_cnt_q,  recv_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      base_q      <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values, independent of statement order.
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state gets a default first, so no branch can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;

    bus.ic_fill_valid = 1'b0;
    bus.ic_fill_idx   = '0;
    bus.ic_fill_data  = '0;
    bus.ic_done       = 1'b0;
    bus.dc_fill_valid = 1'b0;
    bus.dc_fill_idx   = '0;
    bus.dc_fill_data  = '0;
    bus.dc_done       = 1'b0;
    bus.mem_en        = 1'b0;
    bus.mem_wr        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.busy          = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.dc_req) begin
          owner_d = OWN_DC;
          base_d  = block_base(bus.dc_addr);
          waddr_d = bus.dc_addr;
          wdata_d = bus.dc_wdata;
          state_d = bus.dc_we ? ST_WRITE : ST_FILL;
        end else if (bus.ic_req) begin
          owner_d = OWN_IC;
          base_d  = block_base(bus.ic_addr);
          state_d = ST_FILL;
        end
      end

      ST_FILL: begin
        if (issue_cnt_q < ISSUE_END) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = word_addr(base_q, issue_cnt_q[IDX_W-1:0]);
          issue_cnt_d  = issue_cnt_q + cnt_t'(1);
        end
        // Returns are counted, not timed: the memory latency is never assumed here.
        if (bus.mem_rvalid) begin
          if (owner_q == OWN_IC) begin
            bus.ic_fill_valid = 1'b1;
            bus.ic_fill_idx   = recv_cnt_q;
            bus.ic_fill_data  = bus.mem_rdata;
          end else if (owner_q == OWN_DC) begin
            bus.dc_fill_valid = 1'b1;
            bus.dc_fill_idx   = recv_cnt_q;
            bus.dc_fill_data  = bus.mem_rdata;
          end
          recv_cnt_d = recv_cnt_q + idx_t'(1);
          if (recv_cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = waddr_q;
        bus.mem_wdata = wdata_q;
        bus.dc_done   = 1'b1;
        owner_d       = OWN_NONE;
        state_d       = ST_IDLE;
      end

      ST_DONE: begin
        bus.ic_done = (owner_q == OWN_IC);
        bus.dc_done = (owner_q == OWN_DC);
        issue_cnt_d = '0;
        recv_cnt_d  = '0;
        owner_d     = OWN_NONE;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed scenarios push expected memory
// accesses, cache responses and busy snapshots; a monitor pops and compares them.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  typedef enum logic [1:0] {EV_IC_FILL, EV_DC_FILL, EV_IC_DONE, EV_DC_DONE} ev_kind_e;

  typedef struct {
    int    cyc;
    logic  wr;
    addr_t addr;
    data_t wdata;
  } mem_exp_t;

  typedef struct {
    int       cyc;
    ev_kind_e kind;
    idx_t     idx;
    data_t    data;
  } ev_exp_t;

  typedef struct {
    int   cyc;
    logic busy;
  } snap_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  mem_exp_t  mem_q[$];
  ev_exp_t   ev_q[$];
  snap_exp_t snap_q[$];

  // Memory model: four-stage return pipeline, read data equals the byte address.
  logic  pipe_v[4];
  addr_t pipe_a[4];

  cache_mem_arbiter_if bus();

  cache_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish by itself");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic missing(input string name, input int due, input logic [63:0] exp);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: got nothing required %h due at cycle %0d", name, cyc, exp, due);
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: got %h required no activity", name, cyc, act);
  endtask

  task automatic monitor_cycle();
    mem_exp_t  me;
    ev_exp_t   ee;
    snap_exp_t se;
    ev_kind_e  k;
    idx_t      gi;
    data_t     gd;
    logic      seen;

    if (bus.mem_en === 1'b1) begin
      if (mem_q.size() == 0) begin
        unexpected("mem_access", 64'(bus.mem_addr));
      end else begin
        me = mem_q.pop_front();
        check("mem_cycle", 64'(cyc), 64'(me.cyc));
        check("mem_wr", 64'(bus.mem_wr), 64'(me.wr));
        check("mem_addr", 64'(bus.mem_addr), 64'(me.addr));
        if (me.wr) check("mem_wdata", 64'(bus.mem_wdata), 64'(me.wdata));
      end
    end else if (mem_q.size() != 0 && mem_q[0].cyc <= cyc) begin
      me = mem_q.pop_front();
      missing("mem_access", me.cyc, 64'(me.addr));
    end

    seen = 1'b1;
    gi   = '0;
    gd   = '0;
    k    = EV_IC_FILL;
    if (bus.dc_fill_valid === 1'b1) begin
      k = EV_DC_FILL; gi = bus.dc_fill_idx; gd = bus.dc_fill_data;
    end else if (bus.ic_fill_valid === 1'b1) begin
      k = EV_IC_FILL; gi = bus.ic_fill_idx; gd = bus.ic_fill_data;
    end else if (bus.dc_done === 1'b1) begin
      k = EV_DC_DONE;
    end else if (bus.ic_done === 1'b1) begin
      k = EV_IC_DONE;
    end else begin
      seen = 1'b0;
    end

    if (seen) begin
      if (ev_q.size() == 0) begin
        unexpected("cache_event", {62'd0, k});
      end else begin
        ee = ev_q.pop_front();
        check("event_kind", 64'(k), 64'(ee.kind));
        check("event_cycle", 64'(cyc), 64'(ee.cyc));
        if (ee.kind == EV_IC_FILL || ee.kind == EV_DC_FILL) begin
          check("fill_idx", 64'(gi), 64'(ee.idx));
          check("fill_data", 64'(gd), 64'(ee.data));
        end
      end
    end else if (ev_q.size() != 0 && ev_q[0].cyc <= cyc) begin
      ee = ev_q.pop_front();
      missing("cache_event", ee.cyc, {62'd0, ee.kind});
    end

    while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
      se = snap_q.pop_front();
      check("busy", 64'(bus.busy), 64'(se.busy));
      if (!se.busy) begin
        check("idle_mem_outs", 64'({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata}), 64'd0);
        check("idle_cache_outs",
              64'({bus.ic_fill_valid, bus.ic_fill_idx, bus.ic_fill_data, bus.ic_done,
                   bus.dc_fill_valid, bus.dc_fill_idx, bus.dc_done}), 64'd0);
        check("idle_dc_fill_data", 64'(bus.dc_fill_data), 64'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    monitor_cycle();
  end

  // One clock of stimulus: advance the memory model, and let each cache drop its
  // request during its done cycle.
  task automatic cycle();
    @(negedge clk);
    bus.mem_rvalid = pipe_v[3];
    bus.mem_rdata  = pipe_v[3] ? data_t'(pipe_a[3]) : '0;
    for (int i = 3; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = (bus.mem_en === 1'b1) && (bus.mem_wr === 1'b0);
    pipe_a[0] = bus.mem_addr;
    if (bus.ic_done === 1'b1) bus.ic_req = 1'b0;
    if (bus.dc_done === 1'b1) bus.dc_req = 1'b0;
  endtask

  task automatic push_fill(input ev_kind_e fk, input ev_kind_e dk, input addr_t base, input int g);
    for (int i = 0; i < 8; i++) begin
      mem_q.push_back('{g + 1 + i, 1'b0, base + addr_t'(2 * i), '0});
      ev_q.push_back('{g + 5 + i, fk, idx_t'(i), data_t'(base + addr_t'(2 * i))});
    end
    ev_q.push_back('{g + 13, dk, '0, '0});
    snap_q.push_back('{g + 13, 1'b1});
    snap_q.push_back('{g + 14, 1'b0});
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && (mem_q.size() + ev_q.size() + snap_q.size()) != 0; n++) begin
      cycle();
    end
    repeat (2) cycle();
  endtask

  initial begin
    int g;
    rst            = 1'b1;
    bus.ic_req     = 1'b0;
    bus.ic_addr    = '0;
    bus.dc_req     = 1'b0;
    bus.dc_we      = 1'b0;
    bus.dc_addr    = '0;
    bus.dc_wdata   = '0;
    bus.mem_rdata  = '0;
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = '0;
    end

    for (int c = 1; c <= 4; c++) snap_q.push_back('{c, 1'b0});
    repeat (4) cycle();
    rst = 1'b0;
    drain(10);

    // Basic I-cache fill from a mid-block address.
    cycle();
    g = cyc;
    bus.ic_req  = 1'b1;
    bus.ic_addr = 16'h0126;
    snap_q.push_back('{g + 1, 1'b1});
    push_fill(EV_IC_FILL, EV_IC_DONE, 16'h0120, g);
    drain(40);

    // Simultaneous requests: D-cache wins, I-cache follows after the next IDLE.
    cycle();
    g = cyc;
    bus.dc_req  = 1'b1;
    bus.dc_we   = 1'b0;
    bus.dc_addr = 16'h2000;
    bus.ic_req  = 1'b1;
    bus.ic_addr = 16'h0446;
    push_fill(EV_DC_FILL, EV_DC_DONE, 16'h2000, g);
    push_fill(EV_IC_FILL, EV_IC_DONE, 16'h0440, g + 14);
    drain(60);

    // Write-through store: one cycle, done in the same cycle.
    cycle();
    g = cyc;
    bus.dc_req   = 1'b1;
    bus.dc_we    = 1'b1;
    bus.dc_addr  = 16'h1000;
    bus.dc_wdata = 16'hBEEF;
    mem_q.push_back('{g + 1, 1'b1, 16'h1000, 16'hBEEF});
    ev_q.push_back('{g + 1, EV_DC_DONE, '0, '0});
    snap_q.push_back('{g + 1, 1'b1});
    snap_q.push_back('{g + 2, 1'b0});
    drain(20);
    bus.dc_we = 1'b0;

    // D-cache request arrives mid I-cache fill and must wait.
    cycle();
    g = cyc;
    bus.ic_req  = 1'b1;
    bus.ic_addr = 16'h0A0C;
    push_fill(EV_IC_FILL, EV_IC_DONE, 16'h0A00, g);
    push_fill(EV_DC_FILL, EV_DC_DONE, 16'h3000, g + 14);
    while (cyc < g + 8) cycle();
    bus.dc_req  = 1'b1;
    bus.dc_we   = 1'b0;
    bus.dc_addr = 16'h3006;
    drain(60);

    // Reset after the third return; late returns must be dropped.
    cycle();
    g = cyc;
    bus.ic_req  = 1'b1;
    bus.ic_addr = 16'h0500;
    for (int i = 0; i < 7; i++) mem_q.push_back('{g + 1 + i, 1'b0, 16'h0500 + addr_t'(2 * i), '0});
    for (int i = 0; i < 3; i++) ev_q.push_back('{g + 5 + i, EV_IC_FILL, idx_t'(i), 16'h0500 + data_t'(2 * i)});
    for (int c = 8; c <= 11; c++) snap_q.push_back('{g + c, 1'b0});
    while (cyc < g + 7) cycle();
    rst        = 1'b1;
    bus.ic_req = 1'b0;
    repeat (4) cycle();
    rst = 1'b0;
    repeat (2) cycle();
    g = cyc;
    bus.ic_req  = 1'b1;
    bus.ic_addr = 16'h0500;
    push_fill(EV_IC_FILL, EV_IC_DONE, 16'h0500, g);
    drain(40);

    // Top-of-memory block: addresses stay inside 0xFFF0..0xFFFE.
    cycle();
    g = cyc;
    bus.ic_req  = 1'b1;
    bus.ic_addr = 16'hFFF8;
    push_fill(EV_IC_FILL, EV_IC_DONE, 16'hFFF0, g);
    drain(40);

    repeat (3) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
